fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter sharing one 16-bit FIFO between NUM_REQ producers.
- Drives the FIFO's write, data_in and clear inputs; watches its full flag.
- Grants bursts of up to MAX_BURST words per producer.
- Sequences a FIFO flush on request, pre-empting any active grant.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM state encoding and statistics counter width.
package fifo_arb_pkg;

   localparam int STAT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      FLUSH = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after last_owner+1, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_owner,
   output logic               found,
   output logic [IW-1:0]      index
);

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IW'(sum);
   endfunction

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[wrap_add(last_owner, k)]) begin
            found = 1'b1;
            index = wrap_add(last_owner, k);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter sharing one FIFO between NUM_REQ producers, with flush sequencing.
// Optional per-requester word counters enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          ack,
   input  logic                        clr_req,
   input  logic                        fifo_full,
   output logic                        fifo_write,
   output logic [DATA_W-1:0]           fifo_data,
   output logic                        fifo_clear,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy,
   output logic [NUM_REQ*STAT_W-1:0]   stat_words
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   last_owner_q, last_owner_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic            clear_q, clear_d;
   logic            pick_found;
   logic [IW-1:0]   pick_index;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req        (req),
      .last_owner (last_owner_q),
      .found      (pick_found),
      .index      (pick_index)
   );

   // Write-side outputs decode only registered state/owner plus live req/full/clr.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      fifo_write   = 1'b0;
      fifo_data    = '0;
      ack          = '0;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = FLUSH;
            end else if (pick_found) begin
               owner_d     = pick_index;
               burst_cnt_d = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (clr_req) begin
               last_owner_d = owner_q;
               state_d      = FLUSH;
            end else if (req[owner_q]) begin
               if (!fifo_full) begin
                  fifo_write   = 1'b1;
                  fifo_data    = req_data[int'(owner_q)*DATA_W +: DATA_W];
                  ack[owner_q] = 1'b1;
                  burst_cnt_d  = burst_cnt_q + BW'(1);
                  if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
                     last_owner_d = owner_q;
                     state_d      = IDLE;
                  end
               end
            end else begin
               last_owner_d = owner_q;
               state_d      = IDLE;
            end
         end
         FLUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      clear_d = (state_d == FLUSH);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= IW'(NUM_REQ - 1);
         burst_cnt_q  <= '0;
         clear_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         clear_q      <= clear_d;
      end
   end

   assign fifo_clear = clear_q;
   assign grant_id   = owner_q;
   assign busy       = (state_q != IDLE);

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NUM_REQ];
   logic [STAT_W-1:0] stat_d [NUM_REQ];

   // Counters saturate rather than wrap and are wiped alongside the FIFO contents.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_d[i] = stat_q[i];
         if (state_q == FLUSH) begin
            stat_d[i] = '0;
         end else if (ack[i] && (stat_q[i] != {STAT_W{1'b1}})) begin
            stat_d[i] = stat_q[i] + STAT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= stat_d[i];
      end
   end

   always_comb begin
      stat_words = '0;
      for (int i = 0; i < NUM_REQ; i++) stat_words[i*STAT_W +: STAT_W] = stat_q[i];
   end
`else
   assign stat_words = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer queues drive requests, a scoreboard checks written words.
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 16;

   logic                       clock;
   logic                       reset;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*DATA_W-1:0]  req_data;
   logic [NUM_REQ-1:0]         ack;
   logic                       clr_req;
   logic                       fifo_full;
   logic                       fifo_write;
   logic [DATA_W-1:0]          fifo_data;
   logic                       fifo_clear;
   logic [1:0]                 grant_id;
   logic                       busy;
   logic [NUM_REQ*16-1:0]      stat_words;

   int n_cmp;
   int n_bad;

   logic [15:0] src_q [NUM_REQ][$];
   logic [15:0] exp_q [NUM_REQ][$];

   logic        obs_write;
   logic [3:0]  obs_ack;
   logic [15:0] obs_data;
   logic [1:0]  obs_grant;
   logic        obs_busy;
   logic        obs_clear;

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .clr_req    (clr_req),
      .fifo_full  (fifo_full),
      .fifo_write (fifo_write),
      .fifo_data  (fifo_data),
      .fifo_clear (fifo_clear),
      .grant_id   (grant_id),
      .busy       (busy),
      .stat_words (stat_words)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Scoreboard: every FIFO write must match the oldest outstanding word of the acked requester.
   always @(negedge clock) begin
      int id;
      logic [15:0] e;
      if (reset === 1'b1) begin
         n_cmp++;
         if ((ack != 4'b0) !== fifo_write) begin
            n_bad++;
            $display("[TB] FAIL ack_vs_write: ack=%b write=%b, required ack nonzero exactly when writing", ack, fifo_write);
         end
         if (fifo_write === 1'b1) begin
            n_cmp++;
            if (fifo_full !== 1'b0) begin
               n_bad++;
               $display("[TB] FAIL write_while_full: write=1 full=%b, required full=0", fifo_full);
            end
            n_cmp++;
            if (!$onehot(ack)) begin
               n_bad++;
               $display("[TB] FAIL ack_onehot: ack=%b, required one-hot", ack);
            end else begin
               id = 0;
               for (int i = 0; i < NUM_REQ; i++) if (ack[i]) id = i;
               n_cmp++;
               if (exp_q[id].size() == 0) begin
                  n_bad++;
                  $display("[TB] FAIL unexpected_write: req %0d data %0h, required no write", id, fifo_data);
               end else begin
                  e = exp_q[id].pop_front();
                  if (fifo_data !== e) begin
                     n_bad++;
                     $display("[TB] FAIL write_data: req %0d got %0h, required %0h", id, fifo_data, e);
                  end
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit src_empty();
      for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int exp_left();
      int n;
      n = 0;
      for (int i = 0; i < NUM_REQ; i++) n += exp_q[i].size();
      return n;
   endfunction

   task automatic load(input int id, input int base, input int n);
      logic [15:0] w;
      for (int k = 0; k < n; k++) begin
         w = 16'(base + k);
         src_q[id].push_back(w);
         exp_q[id].push_back(w);
      end
   endtask

   task automatic apply_reset();
      reset     = 1'b0;
      req       = '0;
      req_data  = '0;
      clr_req   = 1'b0;
      fifo_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // One clock of producer behaviour: present head words, sample outputs, retire acked words.
   task automatic cycle();
      logic [15:0] tmp;
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i] = (src_q[i].size() != 0);
         req_data[i*16 +: 16] = (src_q[i].size() != 0) ? src_q[i][0] : 16'h0;
      end
      @(negedge clock);
      obs_write = fifo_write;
      obs_ack   = ack;
      obs_data  = fifo_data;
      obs_grant = grant_id;
      obs_busy  = busy;
      obs_clear = fifo_clear;
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (obs_ack[i] && src_q[i].size() != 0) tmp = src_q[i].pop_front();
      end
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      req       = '1;
      req_data  = {16'd4, 16'd3, 16'd2, 16'd1};
      clr_req   = 1'b0;
      fifo_full = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++;
      if ({fifo_write, ack, busy, fifo_clear, grant_id, fifo_data} !== 25'b0) begin
         n_bad++;
         $display("[TB] FAIL reset_outputs: write=%b ack=%b busy=%b clear=%b grant=%0d data=%0h, required all 0",
                  fifo_write, ack, busy, fifo_clear, grant_id, fifo_data);
      end
      n_cmp++;
      if (stat_words !== 64'b0) begin
         n_bad++;
         $display("[TB] FAIL reset_stats: got %0h, required 0", stat_words);
      end
      apply_reset();
      cycle();
      n_cmp++;
      if (obs_busy !== 1'b0 || obs_write !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL reset_idle: busy=%b write=%b, required 0/0", obs_busy, obs_write);
      end
   endtask

   task automatic test_single_producer();
      apply_reset();
      src_q[0].push_back(16'd100); exp_q[0].push_back(16'd100);
      src_q[0].push_back(16'd150); exp_q[0].push_back(16'd150);
      src_q[0].push_back(16'd200); exp_q[0].push_back(16'd200);
      cycle();
      n_cmp++;
      if (obs_write !== 1'b0 || obs_busy !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL single_arb_cycle: write=%b busy=%b, required 0/0", obs_write, obs_busy);
      end
      for (int k = 0; k < 3; k++) begin
         cycle();
         n_cmp++;
         if (obs_write !== 1'b1 || obs_ack !== 4'b0001 || obs_grant !== 2'd0) begin
            n_bad++;
            $display("[TB] FAIL single_write%0d: write=%b ack=%b grant=%0d, required 1/0001/0", k, obs_write, obs_ack, obs_grant);
         end
      end
      cycle();
      n_cmp++;
      if (obs_write !== 1'b0 || obs_busy !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL single_drop: write=%b busy=%b, required 0/1", obs_write, obs_busy);
      end
      cycle();
      n_cmp++;
      if (obs_busy !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL single_back_idle: busy=%b, required 0", obs_busy);
      end
      n_cmp++;
      if (exp_left() != 0) begin
         n_bad++;
         $display("[TB] FAIL single_left: %0d words unwritten, required 0", exp_left());
      end
   endtask

   task automatic test_fairness();
      int owner;
      apply_reset();
      load(0, 16'h1000, 8);
      load(1, 16'h2000, 4);
      load(2, 16'h3000, 4);
      load(3, 16'h4000, 4);
      for (int g = 0; g < 5; g++) begin
         owner = g % NUM_REQ;
         cycle();
         n_cmp++;
         if (obs_write !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL fair_gap%0d: write=%b, required 0", g, obs_write);
         end
         for (int w = 0; w < 4; w++) begin
            cycle();
            n_cmp++;
            if (obs_ack !== 4'(1 << owner) || obs_grant !== 2'(owner)) begin
               n_bad++;
               $display("[TB] FAIL fair_grant%0d_word%0d: ack=%b grant=%0d, required %b/%0d",
                        g, w, obs_ack, obs_grant, 4'(1 << owner), owner);
            end
         end
      end
      cycle();
      n_cmp++;
      if (obs_busy !== 1'b0 || exp_left() != 0) begin
         n_bad++;
         $display("[TB] FAIL fair_end: busy=%b left=%0d, required 0/0", obs_busy, exp_left());
      end
   endtask

   task automatic test_full_stall();
      apply_reset();
      load(0, 16'h0A00, 5);
      cycle();
      for (int k = 0; k < 2; k++) begin
         cycle();
         n_cmp++;
         if (obs_write !== 1'b1 || obs_ack !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL stall_pre%0d: write=%b ack=%b, required 1/0001", k, obs_write, obs_ack);
         end
      end
      fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         n_cmp++;
         if (obs_write !== 1'b0 || obs_ack !== 4'b0 || obs_busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL stall_hold%0d: write=%b ack=%b busy=%b, required 0/0000/1", k, obs_write, obs_ack, obs_busy);
         end
      end
      fifo_full = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cycle();
         n_cmp++;
         if (obs_write !== 1'b1 || obs_ack !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL stall_post%0d: write=%b ack=%b, required 1/0001", k, obs_write, obs_ack);
         end
      end
      cycle();
      n_cmp++;
      if (obs_busy !== 1'b0 || obs_write !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL stall_burst_end: busy=%b write=%b, required 0/0", obs_busy, obs_write);
      end
      cycle();
      n_cmp++;
      if (obs_write !== 1'b1 || obs_ack !== 4'b0001) begin
         n_bad++;
         $display("[TB] FAIL stall_regrant: write=%b ack=%b, required 1/0001", obs_write, obs_ack);
      end
      cycle();
      n_cmp++;
      if (exp_left() != 0) begin
         n_bad++;
         $display("[TB] FAIL stall_left: %0d words unwritten, required 0", exp_left());
      end
   endtask

   task automatic test_flush();
      logic [4:0] clr_seen;
      apply_reset();
      load(0, 16'h5000, 4);
      load(1, 16'h6000, 4);
      cycle();
      cycle();
      cycle();
      clr_req = 1'b1;
      cycle();
      n_cmp++;
      if (obs_write !== 1'b0 || obs_ack !== 4'b0 || obs_clear !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL flush_preempt: write=%b ack=%b clear=%b, required 0/0000/0", obs_write, obs_ack, obs_clear);
      end
      clr_req = 1'b0;
      cycle();
      n_cmp++;
      if (obs_clear !== 1'b1 || obs_busy !== 1'b1 || obs_write !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL flush_cycle: clear=%b busy=%b write=%b, required 1/1/0", obs_clear, obs_busy, obs_write);
      end
      cycle();
      n_cmp++;
      if (obs_clear !== 1'b0 || obs_busy !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL flush_done: clear=%b busy=%b, required 0/0", obs_clear, obs_busy);
      end
      cycle();
      n_cmp++;
      if (obs_ack !== 4'b0010 || obs_grant !== 2'd1) begin
         n_bad++;
         $display("[TB] FAIL flush_next_owner: ack=%b grant=%0d, required 0010/1", obs_ack, obs_grant);
      end
      for (int c = 0; c < 40 && !src_empty(); c++) cycle();
      cycle();
      n_cmp++;
      if (exp_left() != 0) begin
         n_bad++;
         $display("[TB] FAIL flush_drain: %0d words unwritten, required 0", exp_left());
      end
      clr_req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle();
         clr_seen[c] = obs_clear;
      end
      clr_req = 1'b0;
      cycle();
      clr_seen[4] = obs_clear;
      n_cmp++;
      if (clr_seen !== 5'b01010) begin
         n_bad++;
         $display("[TB] FAIL flush_held: clear pattern %b (cycle0 at lsb), required 01010", clr_seen);
      end
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      load(1, 16'h7000, 4);
      cycle();
      cycle();
      cycle();
      n_cmp++;
      if (obs_ack !== 4'b0010) begin
         n_bad++;
         $display("[TB] FAIL midrst_setup: ack=%b, required 0010", obs_ack);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({fifo_write, ack, busy, fifo_clear, grant_id, fifo_data} !== 25'b0) begin
         n_bad++;
         $display("[TB] FAIL midrst_async: write=%b ack=%b busy=%b clear=%b grant=%0d data=%0h, required all 0",
                  fifo_write, ack, busy, fifo_clear, grant_id, fifo_data);
      end
      @(posedge clock);
      #1;
      load(0, 16'h8000, 2);
      reset = 1'b1;
      cycle();
      n_cmp++;
      if (obs_write !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL midrst_arb: write=%b, required 0", obs_write);
      end
      cycle();
      n_cmp++;
      if (obs_ack !== 4'b0001 || obs_grant !== 2'd0) begin
         n_bad++;
         $display("[TB] FAIL midrst_first_grant: ack=%b grant=%0d, required 0001/0", obs_ack, obs_grant);
      end
      for (int c = 0; c < 40 && !src_empty(); c++) cycle();
      cycle();
      n_cmp++;
      if (exp_left() != 0) begin
         n_bad++;
         $display("[TB] FAIL midrst_drain: %0d words unwritten, required 0", exp_left());
      end
   endtask

   task automatic test_stats();
`ifdef FIFO_ARB_STATS_EN
      apply_reset();
      load(1, 0, 65540);
      for (int c = 0; c < 90000 && !src_empty(); c++) cycle();
      n_cmp++;
      if (stat_words !== {16'h0, 16'h0, 16'hFFFF, 16'h0}) begin
         n_bad++;
         $display("[TB] FAIL stats_saturate: got %0h, required 0000_0000_ffff_0000", stat_words);
      end
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      cycle();
      n_cmp++;
      if (stat_words !== 64'b0) begin
         n_bad++;
         $display("[TB] FAIL stats_flush: got %0h, required 0", stat_words);
      end
`else
      apply_reset();
      load(2, 16'h9000, 6);
      for (int c = 0; c < 40 && !src_empty(); c++) cycle();
      n_cmp++;
      if (stat_words !== 64'b0) begin
         n_bad++;
         $display("[TB] FAIL stats_disabled: got %0h, required 0", stat_words);
      end
`endif
      n_cmp++;
      if (exp_left() != 0) begin
         n_bad++;
         $display("[TB] FAIL stats_left: %0d words unwritten, required 0", exp_left());
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_single_producer();
      test_fairness();
      test_full_stall();
      test_flush();
      test_reset_mid_burst();
      test_stats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
